// File: rtl/ysyx_23060061_lsu.sv
// Handshaked load/store unit: aligns beats, builds byte masks, extends load data.
// Define YSYX_23060061_LSU_MISALIGN_EN to allow misaligned accesses (split into two beats when crossing a word).
module ysyx_23060061_lsu #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [2:0]          req_funct3,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata
);
  // state | meaning
  // IDLE  | ready for a request
  // REQ0  | first beat on the bus
  // WAIT0 | waiting for first beat completion
  // REQ1  | second beat of a word-crossing access
  // WAIT1 | waiting for second beat completion
  // RESP  | one-cycle response to the core
  localparam int NB   = DATA_W / 8;
  localparam int OFFW = $clog2(NB);

  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} stateT;

  stateT               state, stateNext;
  logic                weQ, errQ, reqIllegal;
  logic [2:0]          funct3Q;
  logic [ADDR_W-1:0]   addrQ, alignedAddr;
  logic [DATA_W-1:0]   wdataQ, beat0Q, wdata0, raw, lowMask, loadExt;
  logic [NB-1:0]       mask0;
  logic [2*NB-1:0]     sizeOnes;
  logic [OFFW-1:0]     offset;
  logic [OFFW+2:0]     byteShift;
  logic                signBit;

  assign offset      = addrQ[OFFW-1:0];
  assign byteShift   = {offset, 3'b000};
  assign alignedAddr = {addrQ[ADDR_W-1:OFFW], {OFFW{1'b0}}};

`ifdef YSYX_23060061_LSU_MISALIGN_EN
  logic [DATA_W-1:0]   beat1Q, wdata1;
  logic [NB-1:0]       mask1;
  logic [2*NB-1:0]     maskWide;
  logic [2*DATA_W-1:0] dataWide;
  logic                needSecond;

  assign maskWide   = sizeOnes << offset;
  assign mask0      = maskWide[NB-1:0];
  assign mask1      = maskWide[2*NB-1:NB];
  assign needSecond = |mask1;
  assign dataWide   = {{DATA_W{1'b0}}, wdataQ} << byteShift;
  assign wdata0     = dataWide[DATA_W-1:0];
  assign wdata1     = dataWide[2*DATA_W-1:DATA_W];
  assign raw        = DATA_W'({beat1Q, beat0Q} >> byteShift);
`else
  assign mask0  = NB'(sizeOnes << offset);
  assign wdata0 = wdataQ << byteShift;
  assign raw    = beat0Q >> byteShift;
`endif

  always_comb begin
    reqIllegal = (req_funct3 == 3'b111) || (req_funct3[1:0] == 2'b11 && DATA_W == 32) ||
                 (req_we && req_funct3[2]);
`ifndef YSYX_23060061_LSU_MISALIGN_EN
    case (req_funct3[1:0])
      2'b00:   reqIllegal = reqIllegal;
      2'b01:   reqIllegal = reqIllegal || req_addr[0];
      2'b10:   reqIllegal = reqIllegal || (|req_addr[1:0]);
      default: reqIllegal = reqIllegal || (|req_addr[2:0]);
    endcase
`endif
  end

  always_comb begin
    sizeOnes = '0;
    lowMask  = '1;
    signBit  = raw[DATA_W-1];
    case (funct3Q[1:0])
      2'b00: begin sizeOnes = (2*NB)'(8'h01); lowMask = DATA_W'(8'hFF);         signBit = raw[7];  end
      2'b01: begin sizeOnes = (2*NB)'(8'h03); lowMask = DATA_W'(16'hFFFF);      signBit = raw[15]; end
      2'b10: begin sizeOnes = (2*NB)'(8'h0F); lowMask = DATA_W'(32'hFFFFFFFF);  signBit = raw[31]; end
      default: sizeOnes = (2*NB)'(8'hFF);
    endcase
    loadExt = (raw & lowMask) | ((signBit && !funct3Q[2]) ? ~lowMask : '0);
  end

  always_comb begin
    stateNext     = state;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    resp_err      = 1'b0;
    resp_rdata    = '0;
    mem_req_valid = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    mem_wmask     = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) stateNext = reqIllegal ? RESP : REQ0;
      end
      REQ0: begin
        mem_req_valid = 1'b1;
        mem_we        = weQ;
        mem_addr      = alignedAddr;
        mem_wdata     = wdata0;
        mem_wmask     = mask0;
        if (mem_req_ready) stateNext = WAIT0;
      end
      WAIT0: begin
`ifdef YSYX_23060061_LSU_MISALIGN_EN
        if (mem_resp_valid) stateNext = needSecond ? REQ1 : RESP;
`else
        if (mem_resp_valid) stateNext = RESP;
`endif
      end
`ifdef YSYX_23060061_LSU_MISALIGN_EN
      REQ1: begin
        mem_req_valid = 1'b1;
        mem_we        = weQ;
        mem_addr      = alignedAddr + ADDR_W'(NB);
        mem_wdata     = wdata1;
        mem_wmask     = mask1;
        if (mem_req_ready) stateNext = WAIT1;
      end
      WAIT1: begin
        if (mem_resp_valid) stateNext = RESP;
      end
`endif
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = errQ;
        resp_rdata = (errQ || weQ) ? '0 : loadExt;
        stateNext  = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      weQ     <= 1'b0;
      errQ    <= 1'b0;
      funct3Q <= '0;
      addrQ   <= '0;
      wdataQ  <= '0;
      beat0Q  <= '0;
`ifdef YSYX_23060061_LSU_MISALIGN_EN
      beat1Q  <= '0;
`endif
    end else begin
      state <= stateNext;
      if (state == IDLE && req_valid) begin
        weQ     <= req_we;
        errQ    <= reqIllegal;
        funct3Q <= req_funct3;
        addrQ   <= req_addr;
        wdataQ  <= req_wdata;
      end
      if (state == WAIT0 && mem_resp_valid) beat0Q <= mem_rdata;
`ifdef YSYX_23060061_LSU_MISALIGN_EN
      if (state == WAIT1 && mem_resp_valid) beat1Q <= mem_rdata;
`endif
    end
  end
endmodule

// File: tb/tb_ysyx_23060061_lsu.sv
// Scoreboard bench for ysyx_23060061_lsu (DATA_W=32): expected beats and responses are queued
// at issue time and checked by independent bus-responder and response-monitor processes.
module tb_ysyx_23060061_lsu;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_req_valid, mem_we;
  logic        mem_req_ready = 1'b1;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;
  logic        respAuto = 1'b0, respManual = 1'b0;
  logic [31:0] rdataAuto = '0, rdataManual = '0;

  assign mem_resp_valid = respAuto | respManual;
  assign mem_rdata      = respManual ? rdataManual : rdataAuto;

  always #5 clk = ~clk;

  ysyx_23060061_lsu #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  typedef struct {logic [31:0] rdata; logic err; int cyc;} respT;
  typedef struct {logic [31:0] addr; logic [31:0] wdata; logic [3:0] mask; logic we; logic [31:0] rdata;} beatT;

  respT expResp[$];
  beatT expBeat[$];
  int   compared = 0, mismatched = 0, cyc = 0;
  bit   autoResp = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkIdle(input string name);
    check(name, {req_ready, resp_valid, resp_err, mem_req_valid, mem_we, mem_wmask, resp_rdata, mem_addr, mem_wdata},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0});
  endtask

  function automatic void addBeat(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] mask,
                                  input logic we, input logic [31:0] rdata);
    beatT b;
    b.addr = addr; b.wdata = wdata; b.mask = mask; b.we = we; b.rdata = rdata;
    expBeat.push_back(b);
  endfunction

  // Bus responder: checks each accepted beat, then returns a one-cycle completion.
  initial forever begin
    beatT b;
    @(negedge clk);
    if (mem_req_valid === 1'b1 && mem_req_ready === 1'b1) begin
      if (expBeat.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL unexpected_beat: addr %0h mask %0h", mem_addr, mem_wmask);
      end else begin
        b = expBeat.pop_front();
        check("beat_addr", mem_addr, b.addr);
        check("beat_mask", mem_wmask, b.mask);
        check("beat_we", mem_we, b.we);
        if (b.we) check("beat_wdata", mem_wdata, b.wdata);
        if (autoResp) begin
          @(posedge clk); #1;
          respAuto = 1'b1; rdataAuto = b.rdata;
          @(posedge clk); #1;
          respAuto = 1'b0;
        end
      end
    end
  end

  // Response monitor.
  initial forever begin
    respT e;
    @(negedge clk);
    if (resp_valid === 1'b1) begin
      if (expResp.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL unexpected_resp: rdata %0h err %0b", resp_rdata, resp_err);
      end else begin
        e = expResp.pop_front();
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_err", resp_err, e.err);
        check("resp_cycle", cyc, e.cyc);
      end
    end
  end

  // Beat fields must hold while the bus stalls.
  initial begin
    logic        stalled = 1'b0;
    logic [68:0] held = '0;
    forever begin
      @(negedge clk);
      if (stalled && mem_req_valid === 1'b1) check("stall_stable", {mem_we, mem_wmask, mem_addr, mem_wdata}, held);
      stalled = mem_req_valid === 1'b1 && mem_req_ready === 1'b0;
      held    = {mem_we, mem_wmask, mem_addr, mem_wdata};
    end
  end

  task automatic doReq(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] expRd, input logic expErr, input int expLat, input int hold);
    respT e;
    int   n;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    check("ready_idle", req_ready, 1'b1);
    e.rdata = expRd; e.err = expErr; e.cyc = cyc + expLat;
    expResp.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0; req_wdata = '0;
    mem_req_ready = (hold == 0);
    if (hold == 0) begin
      @(negedge clk);
      check("ready_busy", req_ready, 1'b0);
    end else begin
      repeat (hold) begin
        @(negedge clk);
        check("ready_busy", req_ready, 1'b0);
        @(posedge clk); #1;
      end
      mem_req_ready = 1'b1;
    end
    n = 0;
    while (expResp.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (expResp.size() != 0) begin
      compared++; mismatched++;
      $display("FAIL resp_timeout: addr %0h still pending", addr);
      expResp.delete();
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkIdle("reset_values");
    @(posedge clk); #1;
    rst = 1'b1;

    addBeat(32'h80000000, 32'h0, 4'b1000, 1'b0, 32'h8899AABB);
    doReq(1'b0, 3'b000, 32'h80000003, 32'h0, 32'hFFFFFF88, 1'b0, 3, 0);
    addBeat(32'h80000000, 32'h0, 4'b1000, 1'b0, 32'h8899AABB);
    doReq(1'b0, 3'b100, 32'h80000003, 32'h0, 32'h00000088, 1'b0, 3, 0);
    addBeat(32'h80000000, 32'h0, 4'b1100, 1'b0, 32'h8899AABB);
    doReq(1'b0, 3'b001, 32'h80000002, 32'h0, 32'hFFFF8899, 1'b0, 3, 0);
    addBeat(32'h80000000, 32'h0, 4'b1100, 1'b0, 32'h8899AABB);
    doReq(1'b0, 3'b101, 32'h80000002, 32'h0, 32'h00008899, 1'b0, 3, 0);
    addBeat(32'h80000004, 32'h0, 4'b1111, 1'b0, 32'h12345678);
    doReq(1'b0, 3'b010, 32'h80000004, 32'h0, 32'h12345678, 1'b0, 3, 0);

    addBeat(32'h80000000, 32'hABCD0000, 4'b1100, 1'b1, 32'h0);
    doReq(1'b1, 3'b001, 32'h80000002, 32'h1234ABCD, 32'h0, 1'b0, 3, 0);
    addBeat(32'h80000000, 32'h0000EE00, 4'b0010, 1'b1, 32'h0);
    doReq(1'b1, 3'b000, 32'h80000001, 32'h000000EE, 32'h0, 1'b0, 3, 0);

    doReq(1'b0, 3'b111, 32'h80000000, 32'h0, 32'h0, 1'b1, 1, 0);
    doReq(1'b1, 3'b100, 32'h80000000, 32'h55, 32'h0, 1'b1, 1, 0);
    doReq(1'b0, 3'b011, 32'h80000000, 32'h0, 32'h0, 1'b1, 1, 0);

`ifdef YSYX_23060061_LSU_MISALIGN_EN
    addBeat(32'h80000000, 32'h0, 4'b1110, 1'b0, 32'h44332211);
    addBeat(32'h80000004, 32'h0, 4'b0001, 1'b0, 32'h88776655);
    doReq(1'b0, 3'b010, 32'h80000001, 32'h0, 32'h55443322, 1'b0, 5, 0);
    addBeat(32'h80000000, 32'hAA000000, 4'b1000, 1'b1, 32'h0);
    addBeat(32'h80000004, 32'h00DDCCBB, 4'b0111, 1'b1, 32'h0);
    doReq(1'b1, 3'b010, 32'h80000003, 32'hDDCCBBAA, 32'h0, 1'b0, 5, 0);
    addBeat(32'h80000000, 32'h0, 4'b0110, 1'b0, 32'h8899AABB);
    doReq(1'b0, 3'b101, 32'h80000001, 32'h0, 32'h000099AA, 1'b0, 3, 0);
`else
    doReq(1'b0, 3'b010, 32'h80000001, 32'h0, 32'h0, 1'b1, 1, 0);
    doReq(1'b1, 3'b010, 32'h80000003, 32'hDDCCBBAA, 32'h0, 1'b1, 1, 0);
    doReq(1'b0, 3'b101, 32'h80000001, 32'h0, 32'h0, 1'b1, 1, 0);
`endif

    addBeat(32'h80000008, 32'h11223344, 4'b1111, 1'b1, 32'h0);
    doReq(1'b1, 3'b010, 32'h80000008, 32'h11223344, 32'h0, 1'b0, 6, 3);

    // Reset while waiting for the beat completion: the request must vanish.
    autoResp = 1'b0;
    addBeat(32'h80000010, 32'h0, 4'b1111, 1'b0, 32'h0);
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h80000010;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkIdle("reset_abort");
    @(posedge clk); #1;
    respManual = 1'b1; rdataManual = 32'hDEADBEEF;
    @(posedge clk); #1;
    respManual = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    respManual = 1'b1;
    @(posedge clk); #1;
    respManual = 1'b0;
    repeat (4) begin
      @(negedge clk);
      checkIdle("post_reset_idle");
    end
    autoResp = 1'b1;

    addBeat(32'h80000020, 32'h0, 4'b1111, 1'b0, 32'hCAFEF00D);
    doReq(1'b0, 3'b010, 32'h80000020, 32'h0, 32'hCAFEF00D, 1'b0, 3, 0);

    repeat (3) @(negedge clk);
    check("beats_consumed", expBeat.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
